// File: rtl/data_sram_lsu_if.sv
// data_sram_lsu_if: SRAM-like data bus with an address phase and a data phase.
//   master (LSU) : drives data_req, data_wr, data_size, data_addr, data_wstrb,
//                  data_wdata; receives data_addr_ok, data_data_ok, data_rdata
//   slave  (mem) : the mirror image
interface data_sram_lsu_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_lsu.sv
// data_sram_lsu: MEM-stage load/store unit. Runs one access at a time on the
// SRAM-like data bus, stalls the pipeline (busy) while it is outstanding and
// pulses done for one cycle with the extended load result.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   req_valid                MEM-stage instruction is a load/store
//   memwrite/membyte/memsignext, addr, wdata   decoder fields and operands
//   busy, done, rdata        stall, completion pulse, load result
//   adel, ades               address-error flags, valid with done
//   bus                      data bus, master side
//
// Optional feature: define ADDR_EXCEPT_EN to trap misaligned accesses
// (no bus transaction, adel/ades raised with done one cycle after request).
// Without it, misaligned addresses are silently aligned down on the bus.
module data_sram_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        memwrite,
  input  logic [1:0]  membyte,
  input  logic        memsignext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  data_sram_lsu_if.master bus
);
  localparam logic [1:0] MEM_WORD     = 2'b00;
  localparam logic [1:0] MEM_HALFWORD = 2'b01;

  // Bus size encoding, kept directly in the latched register so that the
  // reset value of the register is the reset value of data_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_n;

  logic        wr_q, sext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_in;
  logic [31:0] load_ext, shifted;
  logic        accept;

  assign accept = (state == IDLE) && req_valid;

  always_comb begin
    case (membyte)
      MEM_WORD:     size_in = SZ_WORD;
      MEM_HALFWORD: size_in = SZ_HALF;
      default:      size_in = SZ_BYTE;
    endcase
  end

`ifdef ADDR_EXCEPT_EN
  logic mis_in, mis_q;
  assign mis_in = ((size_in == SZ_HALF) && addr[0]) ||
                  ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Next state and handshake outputs
  always_comb begin
    state_n  = state;
    busy     = 1'b0;
    done     = 1'b0;
    bus.data_req = 1'b0;
    case (state)
      IDLE: begin
        busy = req_valid;
        if (req_valid) begin
`ifdef ADDR_EXCEPT_EN
          state_n = mis_in ? DONE : ADDR;
`else
          state_n = ADDR;
`endif
        end
      end
      ADDR: begin
        busy = 1'b1;
        bus.data_req = 1'b1;
        if (bus.data_addr_ok) state_n = DATA;
      end
      DATA: begin
        busy = 1'b1;
        if (bus.data_data_ok) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Load extraction: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted = bus.data_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: load_ext = sext_q ? {{24{shifted[7]}}, shifted[7:0]}
                                 : {24'b0, shifted[7:0]};
      SZ_HALF: load_ext = sext_q ? {{16{shifted[15]}}, shifted[15:0]}
                                 : {16'b0, shifted[15:0]};
      default: load_ext = bus.data_rdata;
    endcase
  end

  // Request latch and load result capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef ADDR_EXCEPT_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        wr_q    <= memwrite;
        sext_q  <= memsignext;
        size_q  <= size_in;
        addr_q  <= addr;
        wdata_q <= wdata;
        rdata_q <= '0;  // a trapped access completes with rdata=0
`ifdef ADDR_EXCEPT_EN
        mis_q   <= mis_in;
`endif
      end
      if ((state == DATA) && bus.data_data_ok) rdata_q <= load_ext;
    end
  end

  // Bus outputs come only from latched registers, so they stay constant for
  // the whole address phase regardless of what the pipeline does.
  always_comb begin
    bus.data_wr   = wr_q;
    bus.data_size = size_q;
    case (size_q)
      SZ_WORD: begin
        bus.data_addr  = {addr_q[31:2], 2'b00};
        bus.data_wstrb = 4'b1111;
        bus.data_wdata = wdata_q;
      end
      SZ_HALF: begin
        bus.data_addr  = {addr_q[31:1], 1'b0};
        bus.data_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        bus.data_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        bus.data_addr  = addr_q;
        bus.data_wstrb = 4'b0001 << addr_q[1:0];
        bus.data_wdata = {4{wdata_q[7:0]}};
      end
    endcase
    if (!wr_q) bus.data_wstrb = 4'b0000;
  end

  assign rdata = rdata_q;

`ifdef ADDR_EXCEPT_EN
  assign adel = done && mis_q && !wr_q;
  assign ades = done && mis_q &&  wr_q;
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_lsu.sv
module tb_data_sram_lsu;
  localparam logic [1:0] MEM_WORD = 2'b00, MEM_HALF = 2'b01, MEM_BYTE = 2'b10;

  logic        clk, resetn, req_valid, memwrite, memsignext;
  logic [1:0]  membyte;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, adel, ades;

  data_sram_lsu_if bus_if();

  data_sram_lsu dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .memwrite(memwrite),
    .membyte(membyte), .memsignext(memsignext), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .adel(adel), .ades(ades),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Results of the last run_acc
  int          r_done_cyc, r_done_cnt, r_req_cnt, r_req_first, r_busy_cnt;
  logic        r_busy0, r_stable, r_wr, r_adel, r_ades;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr, r_wdata, r_rdata;

  // One access, cycle 0 = request cycle. The slave raises addr_ok only in
  // cycle ac and data_ok only in cycle dc. req_valid drops after done.
  task automatic run_acc(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int ac, input int dc);
    logic seen;
    seen = 1'b0;
    r_done_cyc = -1; r_done_cnt = 0; r_req_cnt = 0; r_req_first = -1;
    r_busy_cnt = 0; r_stable = 1'b1; r_busy0 = 1'b0;
    r_wr = 1'b0; r_adel = 1'b0; r_ades = 1'b0; r_size = '0; r_wstrb = '0;
    r_addr = '0; r_wdata = '0; r_rdata = '0;
    for (int c = 0; c < 12; c++) begin
      req_valid = !seen; memwrite = wr; membyte = sz; memsignext = sx;
      addr = a; wdata = wd;
      bus_if.data_addr_ok = (c == ac);
      bus_if.data_data_ok = (c == dc);
      bus_if.data_rdata   = rd;
      #1;
      if (c == 0) r_busy0 = busy;
      if (busy) r_busy_cnt++;
      if (bus_if.data_req) begin
        if (r_req_cnt == 0) begin
          r_req_first = c; r_wr = bus_if.data_wr; r_size = bus_if.data_size;
          r_addr = bus_if.data_addr; r_wstrb = bus_if.data_wstrb;
          r_wdata = bus_if.data_wdata;
        end else if (r_wr !== bus_if.data_wr || r_size !== bus_if.data_size ||
                     r_addr !== bus_if.data_addr || r_wstrb !== bus_if.data_wstrb ||
                     r_wdata !== bus_if.data_wdata) begin
          r_stable = 1'b0;
        end
        r_req_cnt++;
      end
      if (done) begin
        r_done_cnt++;
        if (!seen) begin
          r_done_cyc = c; r_rdata = rdata; r_adel = adel; r_ades = ades;
        end
        seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
  endtask

  initial begin
    int rises, first_done, second_rise, second_done, done_seen;
    logic prev_req;
    resetn = 1'b0; req_valid = 1'b0; memwrite = 1'b0; membyte = MEM_WORD;
    memsignext = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
    bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata = 32'h0;
    tick(); tick();

    // Reset state
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_req", bus_if.data_req, 0); check("rst_wr", bus_if.data_wr, 0);
    check("rst_size", bus_if.data_size, 0);
    check("rst_addr", bus_if.data_addr, 0);
    check("rst_wstrb", bus_if.data_wstrb, 0);
    check("rst_wdata", bus_if.data_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_adel", adel, 0);       check("rst_ades", ades, 0);
    resetn = 1'b1;
    tick();

    // lb, immediate handshakes
    run_acc(0, MEM_BYTE, 1, 32'h1000_0003, 0, 32'h80FF_1234, 1, 2);
    check("lb_busy0", r_busy0, 1);
    check("lb_req_first", r_req_first, 1);
    check("lb_size", r_size, 0);
    check("lb_wstrb", r_wstrb, 0);
    check("lb_addr", r_addr, 32'h1000_0003);
    check("lb_done_cyc", r_done_cyc, 3);
    check("lb_busy_cnt", r_busy_cnt, 3);
    check("lb_rdata", r_rdata, 32'hFFFF_FF80);

    // lbu, same access
    run_acc(0, MEM_BYTE, 0, 32'h1000_0003, 0, 32'h80FF_1234, 1, 2);
    check("lbu_rdata", r_rdata, 32'h0000_0080);

    // sh to upper half
    run_acc(1, MEM_HALF, 0, 32'h1000_0002, 32'h1234_ABCD, 0, 1, 2);
    check("sh_wr", r_wr, 1);
    check("sh_size", r_size, 1);
    check("sh_wstrb", r_wstrb, 4'b1100);
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check("sh_addr", r_addr, 32'h1000_0002);
    check("sh_done_cyc", r_done_cyc, 3);
    check("sh_done_cnt", r_done_cnt, 1);

    // lh / lhu / sb
    run_acc(0, MEM_HALF, 1, 32'h1000_0002, 0, 32'h8001_7FFF, 1, 2);
    check("lh_rdata", r_rdata, 32'hFFFF_8001);
    run_acc(0, MEM_HALF, 0, 32'h1000_0000, 0, 32'h8001_7FFF, 1, 2);
    check("lhu_rdata", r_rdata, 32'h0000_7FFF);
    run_acc(1, MEM_BYTE, 0, 32'h1000_0001, 32'h1234_565A, 0, 1, 2);
    check("sb_wstrb", r_wstrb, 4'b0010);
    check("sb_wdata", r_wdata, 32'h5A5A_5A5A);

    // lw with delayed addr_ok (cycle 4) and data_ok (cycle 6)
    run_acc(0, MEM_WORD, 0, 32'h1000_0004, 0, 32'hDEAD_BEEF, 4, 6);
    check("lwd_req_cnt", r_req_cnt, 4);
    check("lwd_stable", r_stable, 1);
    check("lwd_size", r_size, 2);
    check("lwd_busy_cnt", r_busy_cnt, 7);
    check("lwd_done_cyc", r_done_cyc, 7);
    check("lwd_rdata", r_rdata, 32'hDEAD_BEEF);

    // Misaligned lw
    run_acc(0, MEM_WORD, 0, 32'h1000_0002, 0, 32'h1111_2222, 1, 2);
`ifdef ADDR_EXCEPT_EN
    check("mis_lw_done_cyc", r_done_cyc, 1);
    check("mis_lw_req_cnt", r_req_cnt, 0);
    check("mis_lw_adel", r_adel, 1);
    check("mis_lw_ades", r_ades, 0);
    check("mis_lw_rdata", r_rdata, 0);
    run_acc(1, MEM_HALF, 0, 32'h1000_0001, 32'h55, 0, 1, 2);
    check("mis_sh_ades", r_ades, 1);
    check("mis_sh_adel", r_adel, 0);
    check("mis_sh_req_cnt", r_req_cnt, 0);
`else
    check("mis_lw_addr", r_addr, 32'h1000_0000);
    check("mis_lw_adel", r_adel, 0);
    check("mis_lw_done_cyc", r_done_cyc, 3);
    check("mis_lw_rdata", r_rdata, 32'h1111_2222);
`endif

    // Reset during DATA
    req_valid = 1'b1; memwrite = 1'b0; membyte = MEM_WORD; addr = 32'h1000_0008;
    bus_if.data_addr_ok = 1'b1; bus_if.data_data_ok = 1'b0;
    tick();                     // ADDR
    tick();                     // DATA
    check("rstd_in_data", {31'b0, bus_if.data_req} | {30'b0, busy, 1'b0}, 32'h2);
    resetn = 1'b0;
    tick();
    req_valid = 1'b0; resetn = 1'b1; bus_if.data_addr_ok = 1'b0;
    #1;
    check("rstd_busy", busy, 0);
    check("rstd_req", bus_if.data_req, 0);
    done_seen = 0;
    bus_if.data_data_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1; if (done) done_seen++;
      tick();
    end
    bus_if.data_data_ok = 1'b0;
    check("rstd_no_done", done_seen, 0);

    // Two back-to-back sw
    rises = 0; first_done = -1; second_rise = -1; second_done = -1; prev_req = 1'b0;
    memwrite = 1'b1; membyte = MEM_WORD; addr = 32'h1000_0010; wdata = 32'hCAFE_F00D;
    bus_if.data_addr_ok = 1'b1; bus_if.data_data_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 7);
      #1;
      if (bus_if.data_req && !prev_req) begin
        rises++;
        if (rises == 2) second_rise = c;
      end
      prev_req = bus_if.data_req;
      if (done) begin
        if (first_done < 0) first_done = c; else second_done = c;
      end
      tick();
    end
    req_valid = 1'b0; bus_if.data_addr_ok = 1'b0; bus_if.data_data_ok = 1'b0;
    check("b2b_first_done", first_done, 3);
    check("b2b_gap", second_rise - first_done, 2);
    check("b2b_second_done", second_done, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
